// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle datapath and a word-only memory.
// Sub-word stores are done as read-modify-write; loads are extracted and extended.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        memOp,
    input  logic [2:0]  funct3,
    input  logic [31:0] adr,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] loadData,
    output logic [31:0] memAdr,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    input  logic [31:0] memReadData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MRG  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_adr;
    logic [31:0] r_sd;
    logic [2:0]  r_f3;
    logic        r_op;
    logic        r_fault;
    logic [31:0] r_old;
    logic [31:0] r_merged;
    logic [31:0] r_load;

    logic        w_fault_in;
    logic [31:0] w_ext;
    logic [31:0] w_merge;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    function automatic logic f_fault(input logic op, input logic [2:0] f3,
                                     input logic [1:0] a);
        logic v;
        v = 1'b1;
        case (f3)
            3'b000: v = 1'b0;
            3'b001: v = a[0];
            3'b010: v = (a != 2'b00);
            3'b100: v = op;
            3'b101: v = op | a[0];
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    assign w_fault_in = f_fault(memOp, funct3, adr[1:0]);

    always_comb begin
        w_byte = memReadData[8*r_adr[1:0] +: 8];
        w_half = memReadData[16*r_adr[1] +: 16];
        w_ext  = memReadData;
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = memReadData;
        endcase
    end

    always_comb begin
        w_merge = r_old;
        if (r_f3 == 3'b000)
            w_merge[8*r_adr[1:0] +: 8] = r_sd[7:0];
        else
            w_merge[16*r_adr[1] +: 16] = r_sd[15:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_fault_in)
                        w_next = S_FIN;
                    else if (memOp && funct3 == 3'b010)
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD:    w_next = r_op ? S_MRG : S_FIN;
            S_MRG:   w_next = S_WR;
            S_WR:    w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_adr    <= 32'd0;
            r_sd     <= 32'd0;
            r_f3     <= 3'd0;
            r_op     <= 1'b0;
            r_fault  <= 1'b0;
            r_old    <= 32'd0;
            r_merged <= 32'd0;
            r_load   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_adr   <= adr;
                r_sd    <= storeData;
                r_f3    <= funct3;
                r_op    <= memOp;
                r_fault <= w_fault_in;
            end
            if (r_state == S_RD) begin
                if (r_op)
                    r_old <= memReadData;
                else
                    r_load <= w_ext;
            end
            if (r_state == S_MRG)
                r_merged <= w_merge;
        end
    end

    // Memory-side outputs are pure state decodes so reset clears them at once.
    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_FIN);
        fault        = (r_state == S_FIN) && r_fault;
        memWrite     = (r_state == S_WR);
        memAdr       = 32'd0;
        memWriteData = 32'd0;
        if (r_state == S_RD || r_state == S_MRG || r_state == S_WR)
            memAdr = {r_adr[31:2], 2'b00};
        if (r_state == S_WR)
            memWriteData = (r_f3 == 3'b010) ? r_sd : r_merged;
    end

    assign loadData = r_load;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
// Expected values are hand-computed constants.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        memOp;
    logic [2:0]  funct3;
    logic [31:0] adr;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] loadData;
    logic [31:0] memAdr;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [31:0] memReadData;

    logic [31:0] mem [0:63];
    int          total;
    int          bad;
    int          wcnt;
    int          dcnt;
    logic [31:0] last_wa;
    logic [31:0] last_wd;
    int          lat;
    int          w0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .memOp        (memOp),
        .funct3       (funct3),
        .adr          (adr),
        .storeData    (storeData),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .loadData     (loadData),
        .memAdr       (memAdr),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memReadData  (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memReadData = mem[memAdr[7:2]];

    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAdr[7:2]] <= memWriteData;
            wcnt    <= wcnt + 1;
            last_wa <= memAdr;
            last_wd <= memWriteData;
        end
        if (done)
            dcnt <= dcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       output int n);
        @(negedge clk);
        start     = 1'b1;
        memOp     = op;
        funct3    = f3;
        adr       = a;
        storeData = sd;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        wcnt = 0;
        dcnt = 0;
        last_wa = '0;
        last_wd = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4]  = 32'h8899AABB;
        mem[8]  = 32'h11223344;
        mem[9]  = 32'h55667788;
        mem[20] = 32'hCAFEF00D;
        rst = 1'b1;
        start = 1'b0;
        memOp = 1'b0;
        funct3 = 3'b010;
        adr = '0;
        storeData = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ld", loadData, 32'd0);
        chk("rst_madr", memAdr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        w0 = wcnt;
        run(1'b0, 3'b010, 32'h10, 32'h0, lat);
        chk("lw_lat", lat, 2);
        chk("lw_data", loadData, 32'h8899AABB);
        chk("lw_flt", {31'd0, fault}, 32'd0);
        chk("lw_nowr", wcnt - w0, 0);
        @(negedge clk);
        chk("lw_pulse", {31'd0, done}, 32'd0);

        run(1'b0, 3'b000, 32'h11, 32'h0, lat);
        chk("lb", loadData, 32'hFFFFFFAA);
        run(1'b0, 3'b100, 32'h11, 32'h0, lat);
        chk("lbu", loadData, 32'h000000AA);
        run(1'b0, 3'b001, 32'h12, 32'h0, lat);
        chk("lh", loadData, 32'hFFFF8899);
        run(1'b0, 3'b101, 32'h12, 32'h0, lat);
        chk("lhu", loadData, 32'h00008899);
        run(1'b0, 3'b001, 32'h12, 32'h0, lat);

        w0 = wcnt;
        run(1'b1, 3'b000, 32'h22, 32'h0000005A, lat);
        chk("sb_lat", lat, 4);
        chk("sb_nwr", wcnt - w0, 1);
        chk("sb_wa", last_wa, 32'h20);
        chk("sb_wd", last_wd, 32'h115A3344);
        chk("sb_mem", mem[8], 32'h115A3344);

        run(1'b1, 3'b001, 32'h26, 32'h1234BEEF, lat);
        chk("sh_mem", mem[9], 32'hBEEF7788);
        chk("sh_lat", lat, 4);

        w0 = wcnt;
        run(1'b1, 3'b001, 32'h31, 32'h0000FFFF, lat);
        chk("shm_lat", lat, 1);
        chk("shm_flt", {31'd0, fault}, 32'd1);
        chk("shm_nowr", wcnt - w0, 0);
        chk("shm_ld", loadData, 32'hFFFF8899);
        run(1'b0, 3'b011, 32'h10, 32'h0, lat);
        chk("f011_lat", lat, 1);
        chk("f011_flt", {31'd0, fault}, 32'd1);
        chk("f011_ld", loadData, 32'hFFFF8899);
        run(1'b0, 3'b010, 32'h12, 32'h0, lat);
        chk("lwm_flt", {31'd0, fault}, 32'd1);
        chk("lwm_ld", loadData, 32'hFFFF8899);

        @(negedge clk);
        w0 = wcnt;
        dcnt = 0;
        start = 1'b1;
        memOp = 1'b1;
        funct3 = 3'b010;
        adr = 32'h40;
        storeData = 32'hDEADBEEF;
        @(negedge clk);
        chk("hold_busy1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("hold_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("hold_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 7; i++) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("hold_nwr", wcnt - w0, 4);
        chk("hold_ndone", dcnt, 4);
        chk("hold_mem", mem[16], 32'hDEADBEEF);

        w0 = wcnt;
        @(negedge clk);
        start = 1'b1;
        memOp = 1'b1;
        funct3 = 3'b000;
        adr = 32'h51;
        storeData = 32'h77;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mrg_state", memAdr, 32'h50);
        rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_madr", memAdr, 32'd0);
        chk("ar_ld", loadData, 32'd0);
        chk("ar_mw", {31'd0, memWrite}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("ar_nowr", wcnt - w0, 0);
        chk("ar_mem", mem[20], 32'hCAFEF00D);
        run(1'b0, 3'b010, 32'h10, 32'h0, lat);
        chk("ar_lw_lat", lat, 2);
        chk("ar_lw", loadData, 32'h8899AABB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
